lif_neuron: RTL and testbench
=============================

# lif_neuron

Leaky integrate-and-fire neuron that consumes the signed accumulated synaptic current produced by the `mac` stage and emits one output spike bit per accepted timestep. It sits between a neuron's MAC accumulation and the next layer's `spike_in`. The block keeps a saturating membrane potential with shift-based leak, a threshold comparator and a refractory counter. A one-cycle FIRE state applies the post-spike reset.

## Interface
- `ACC_W`, 16: width of `acc_in` and the membrane potential (signed).
- `VTH`, 64: firing threshold, signed; fire when the new potential is ≥ VTH.
- `V_RESET`, 0: potential loaded on fire, on `clear` and on reset.
- `LEAK_SHIFT`, 4: leak = v >>> LEAK_SHIFT (arithmetic shift).
- `REFRAC`, 2: refractory length in cycles after FIRE; 0 disables refractory.

Ports (clock and reset first):
- `clk` in 1: rising-edge clock, the single clock domain.
- `rst_n` in 1: asynchronous reset, active-low.
- `clear` in 1: synchronous clear of neuron state.
- `in_valid` in 1: `acc_in` holds a timestep's summed current.
- `in_ready` out 1: the block can accept an input this cycle.
- `acc_in` in ACC_W: signed current from `mac`.
- `out_valid` out 1: a timestep result is present (one-cycle pulse).
- `spike_out` out 1: spike for that timestep; meaningful only while `out_valid`=1.
- `vmem` out ACC_W: current membrane potential register (signed).
- `refrac_active` out 1: high while in the REFRAC state.

## Operation
- States are READY, FIRE and REFRAC. Reset state is READY.
- An input is accepted at a rising edge when `in_valid` and `in_ready` are both 1.
- `in_ready` = 1 in READY and REFRAC, and 0 in FIRE.
- **READY, on accept:**
  - v_next = sat(v − (v >>> LEAK_SHIFT) + acc_in), computed in ACC_W+2 bits.
  - Saturate to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - If v_next ≥ VTH: `vmem` ← V_RESET and go to FIRE.
  - Otherwise: `vmem` ← v_next and stay in READY.
- **READY, no accept:** `vmem` holds. There is no leak without an input; leak is applied per timestep, not per clock.
- **FIRE:** lasts exactly one cycle. Next state is REFRAC with the counter loaded to REFRAC, or READY if REFRAC = 0.
- **REFRAC:**
  - Accepted inputs are discarded; `vmem` stays V_RESET.
  - Each discarded input still produces `out_valid`=1 with `spike_out`=0, so timestep alignment with downstream is preserved.
  - The counter decrements every cycle. When the counter is 1, the next state is READY, so REFRAC lasts exactly REFRAC cycles.
- **`out_valid` and `spike_out`:** `out_valid` is the accept strobe registered by one cycle. `spike_out` is 1 only in the cycle the state is FIRE.
- **`clear`:** has priority over `in_valid`. It loads `vmem` ← V_RESET, state ← READY and counter ← 0, and forces `out_valid` and `spike_out` to 0 next cycle. An input presented in the same cycle as `clear` is dropped.
- **`rst_n` low, at any time including mid-FIRE or mid-REFRAC:** takes effect immediately and asynchronously. All outputs go to their reset values and the FSM returns to READY. There is no pending-spike memory.

## Timing
- Reset values:
  - `vmem` = V_RESET, `out_valid` = 0, `spike_out` = 0, `refrac_active` = 0.
  - `in_ready` = 1 (READY). It is driven 1 once `rst_n` is low.
- Latency: input accepted at edge t → `out_valid` (and `spike_out` if firing) valid for the cycle after edge t. `vmem` updates at edge t.
- Throughput:
  - One input per cycle without a spike.
  - A spike costs one stall cycle (FIRE, `in_ready`=0).
  - Inputs during REFRAC are accepted but discarded.
- Upstream must hold `acc_in` and `in_valid` stable while `in_ready`=0.
- The threshold compare uses the saturated v_next. Hitting exactly VTH fires.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-stream. Required: `vmem`=0, `out_valid`=0, `spike_out`=0, `in_ready`=1, `refrac_active`=0, without waiting for a clock edge.
2. **Subthreshold integration.** Three accepted inputs of 20 (defaults). Required: `vmem` = 20, 39, 57; each followed by `out_valid`=1 with `spike_out`=0.
3. **Threshold crossing.** A fourth input of 20 gives 57−3+20=74 ≥ 64. Required next cycle: `spike_out`=1, `out_valid`=1, `in_ready`=0, `vmem`=0.
4. **Refractory.** Hold `in_valid`=1 with `acc_in`=100 continuously. Required:
   - Two REFRAC cycles with `refrac_active`=1, `out_valid`=1, `spike_out`=0, `vmem`=0.
   - Then READY accepts 100 → fire again. Pattern: FIRE, 2×REFRAC, then FIRE repeats.
5. **Negative saturation.** Two inputs of −32768. Required: `vmem` = −32768, then −32768 (saturated from −63488), with no spike.
6. **Clear.** Assert `clear` together with `in_valid` during REFRAC. Required next cycle: READY, `vmem`=0, `out_valid`=0; the input is dropped.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane potential with shift leak,
// threshold fire, one-cycle FIRE state and a refractory counter.
module lif_neuron #(
  parameter int unsigned ACC_W      = 16,
  parameter int          VTH        = 64,
  parameter int          V_RESET    = 0,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned REFRAC     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic                    out_valid,
  output logic                    spike_out,
  output logic signed [ACC_W-1:0] vmem,
  output logic                    refrac_active
);

  localparam int unsigned EXT_W = ACC_W + 2;
  localparam int unsigned CNT_W = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

  localparam logic [1:0] ST_READY  = 2'd0;
  localparam logic [1:0] ST_FIRE   = 2'd1;
  localparam logic [1:0] ST_REFRAC = 2'd2;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] VTH_EXT = EXT_W'(VTH);
  localparam logic signed [ACC_W-1:0] V_RST   = ACC_W'(V_RESET);

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] vmem_q, vmem_d;
  logic                    out_valid_q, out_valid_d;
  logic                    spike_q, spike_d;
  logic                    in_ready_q, in_ready_d;
  logic                    refrac_q, refrac_d;

  logic                    accept;
  logic signed [ACC_W-1:0] leak;
  logic signed [EXT_W-1:0] v_ext, leak_ext, acc_ext, sum_ext, v_sat;
  logic                    fire;

  // Leaky integration in two guard bits, then clamp to the ACC_W range
  always_comb begin
    leak     = vmem_q >>> LEAK_SHIFT;
    v_ext    = {{2{vmem_q[ACC_W-1]}}, vmem_q};
    leak_ext = {{2{leak[ACC_W-1]}}, leak};
    acc_ext  = {{2{acc_in[ACC_W-1]}}, acc_in};
    sum_ext  = v_ext - leak_ext + acc_ext;
    if (sum_ext > SAT_MAX) begin
      v_sat = SAT_MAX;
    end else if (sum_ext < SAT_MIN) begin
      v_sat = SAT_MIN;
    end else begin
      v_sat = sum_ext;
    end
    fire = (v_sat >= VTH_EXT);
  end

  assign accept = in_valid && in_ready_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vmem_d      = vmem_q;
    out_valid_d = 1'b0;
    if (clear) begin
      state_d = ST_READY;
      cnt_d   = '0;
      vmem_d  = V_RST;
    end else begin
      case (state_q)
        ST_READY: begin
          if (accept) begin
            out_valid_d = 1'b1;
            if (fire) begin
              vmem_d  = V_RST;
              state_d = ST_FIRE;
            end else begin
              vmem_d = v_sat[ACC_W-1:0];
            end
          end
        end
        ST_FIRE: begin
          if (REFRAC == 0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_REFRAC;
            cnt_d   = CNT_W'(REFRAC);
          end
        end
        ST_REFRAC: begin
          // Inputs still complete a timestep so downstream stays aligned
          out_valid_d = accept;
          vmem_d      = V_RST;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_READY;
          end
        end
        default: begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      endcase
    end
    spike_d    = (state_d == ST_FIRE);
    in_ready_d = (state_d != ST_FIRE);
    refrac_d   = (state_d == ST_REFRAC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      cnt_q       <= '0;
      vmem_q      <= V_RST;
      out_valid_q <= 1'b0;
      spike_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      refrac_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vmem_q      <= vmem_d;
      out_valid_q <= out_valid_d;
      spike_q     <= spike_d;
      in_ready_q  <= in_ready_d;
      refrac_q    <= refrac_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign spike_out     = spike_q;
  assign vmem          = vmem_q;
  assign refrac_active = refrac_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: per-cycle vector table fed through an
// expected-result queue, plus hand-written asynchronous reset sequences.
module tb_lif_neuron;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] acc_in = '0;
  logic               in_ready;
  logic               out_valid;
  logic               spike_out;
  logic signed [15:0] vmem;
  logic               refrac_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic        clr;
    int          acc;
    logic        ov;
    logic        sp;
    int          vm;
    logic        rdy;
    logic        rf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  lif_neuron dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .acc_in        (acc_in),
    .out_valid     (out_valid),
    .spike_out     (spike_out),
    .vmem          (vmem),
    .refrac_active (refrac_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string what, input int idx, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d required %0d", what, idx, got, req);
    end
  endtask

  task automatic add(input logic iv, input logic clr, input int acc, input logic ov,
                     input logic sp, input int vm, input logic rdy, input logic rf);
    vec_t v;
    v.iv = iv; v.clr = clr; v.acc = acc;
    v.ov = ov; v.sp = sp; v.vm = vm; v.rdy = rdy; v.rf = rf;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus at a negedge, compare after the next posedge
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    in_valid = v.iv;
    clear    = v.clr;
    acc_in   = 16'(v.acc);
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("out_valid", idx, int'(out_valid), int'(e.ov));
    chk("spike_out", idx, int'(spike_out), int'(e.sp));
    chk("vmem", idx, int'(vmem), e.vm);
    chk("in_ready", idx, int'(in_ready), int'(e.rdy));
    chk("refrac_active", idx, int'(refrac_active), int'(e.rf));
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_vmem", idx, int'(vmem), 0);
    chk("rst_out_valid", idx, int'(out_valid), 0);
    chk("rst_spike_out", idx, int'(spike_out), 0);
    chk("rst_in_ready", idx, int'(in_ready), 1);
    chk("rst_refrac", idx, int'(refrac_active), 0);
  endtask

  // Assert reset away from any clock edge and check outputs settle immediately
  task automatic async_reset(input int idx);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(idx);
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t hv;

  initial begin
    // iv clr acc | ov sp vmem rdy rf
    add(1, 0, 20,     1, 0, 20,     1, 0);
    add(1, 0, 20,     1, 0, 39,     1, 0);
    add(1, 0, 20,     1, 0, 57,     1, 0);
    add(1, 0, 20,     1, 1, 0,      0, 0);
    add(1, 0, 100,    0, 0, 0,      1, 1);
    add(1, 0, 100,    1, 0, 0,      1, 1);
    add(1, 0, 100,    1, 0, 0,      1, 0);
    add(1, 0, 100,    1, 1, 0,      0, 0);
    add(1, 0, 100,    0, 0, 0,      1, 1);
    add(1, 0, 100,    1, 0, 0,      1, 1);
    add(1, 1, 100,    0, 0, 0,      1, 0);
    add(1, 0, -32768, 1, 0, -32768, 1, 0);
    add(1, 0, -32768, 1, 0, -32768, 1, 0);
    add(0, 0, 0,      0, 0, -32768, 1, 0);
    add(0, 1, 0,      0, 0, 0,      1, 0);
    add(1, 0, 63,     1, 0, 63,     1, 0);
    add(1, 0, 0,      1, 0, 60,     1, 0);
    add(0, 0, 0,      0, 0, 60,     1, 0);
    add(1, 0, 4,      1, 0, 61,     1, 0);
    add(1, 0, 6,      1, 1, 0,      0, 0);
    add(0, 0, 0,      0, 0, 0,      1, 1);
    add(0, 0, 0,      0, 0, 0,      1, 1);
    add(0, 0, 0,      0, 0, 0,      1, 0);
    add(1, 0, -1,     1, 0, -1,     1, 0);
    add(1, 0, 0,      1, 0, 0,      1, 0);
    add(1, 0, 30,     1, 0, 30,     1, 0);
    add(1, 1, 50,     0, 0, 0,      1, 0);

    #1;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i + 1);

    // Reset mid-stream with a nonzero potential and a live out_valid
    hv.iv = 1; hv.clr = 0; hv.acc = 30; hv.ov = 1; hv.sp = 0; hv.vm = 30; hv.rdy = 1; hv.rf = 0;
    run_vec(hv, 100);
    async_reset(101);

    // Reset during FIRE
    hv.acc = 100; hv.sp = 1; hv.vm = 0; hv.rdy = 0;
    run_vec(hv, 102);
    async_reset(103);

    // Reset during REFRAC
    run_vec(hv, 104);
    hv.iv = 0; hv.acc = 0; hv.ov = 0; hv.sp = 0; hv.rdy = 1; hv.rf = 1;
    run_vec(hv, 105);
    async_reset(106);

    // Normal integration resumes after reset
    hv.iv = 1; hv.acc = 20; hv.ov = 1; hv.vm = 20; hv.rf = 0;
    run_vec(hv, 107);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
